// File: rtl/rdy_vld_src_tx_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : rdy_vld_if
// Brief   : Ready/valid handshake bundle with source and destination views.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
interface rdy_vld_if #(
  parameter int DATA_W = 32
);
  logic              vld;
  logic [DATA_W-1:0] data;
  logic              rdy;

  modport src (output vld, output data, input rdy);
  modport dst (input vld, input data, output rdy);
endinterface
`default_nettype wire

// File: rtl/rdy_vld_src_tx.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : rdy_vld_src_tx
// Brief   : DEPTH-entry FIFO feeding the transmit end of a ready/valid link,
//           with sticky overflow flag and transfer counter.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module rdy_vld_src_tx #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_vld,
  input  logic [DATA_W-1:0]          wr_data,
  output logic                       wr_rdy,
  rdy_vld_if.src                     x,
  output logic [$clog2(DEPTH):0]     fill,
  output logic                       ovf,
  output logic [15:0]                xfer_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PW-1:0]     r_wptr;
  logic [PW-1:0]     r_rptr;
  logic              r_ovf;
  logic [15:0]       r_xfer_cnt;

  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[AW-1:0] == r_rptr[AW-1:0]) && (r_wptr[AW] != r_rptr[AW]);

  assign w_push  = wr_vld && !w_full;
  assign w_pop   = x.vld && x.rdy;

  assign wr_rdy   = !w_full;
  assign x.vld    = !w_empty;
  assign x.data   = r_mem[r_rptr[AW-1:0]];
  assign fill     = r_wptr - r_rptr;
  assign ovf      = r_ovf;
  assign xfer_cnt = r_xfer_cnt;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr[AW-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_ovf      <= 1'b0;
      r_xfer_cnt <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + PW'(1);
      end
      if (w_pop) begin
        r_rptr     <= r_rptr + PW'(1);
        r_xfer_cnt <= r_xfer_cnt + 16'd1;
      end
      // A push offered while full is dropped and remembered until reset.
      if (wr_vld && w_full) begin
        r_ovf <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rdy_vld_src_tx.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : tb_rdy_vld_src_tx
// Brief   : Directed bench for rdy_vld_src_tx with a queue scoreboard.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_rdy_vld_src_tx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_vld;
  logic [31:0] wr_data;
  logic        wr_rdy;
  logic [2:0]  fill;
  logic        ovf;
  logic [15:0] xfer_cnt;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] q_exp [$];
  logic        r_hold = 1'b0;
  logic [31:0] r_hold_data = '0;

  rdy_vld_if #(.DATA_W(32)) x_if ();

  rdy_vld_src_tx #(.DATA_W(32), .DEPTH(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_vld   (wr_vld),
    .wr_data  (wr_data),
    .wr_rdy   (wr_rdy),
    .x        (x_if),
    .fill     (fill),
    .ovf      (ovf),
    .xfer_cnt (xfer_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Scoreboard and stability monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      q_exp.delete();
      r_hold = 1'b0;
    end else begin
      if (r_hold) begin
        chk("stable_vld", 32'(x_if.vld), 32'd1);
        chk("stable_data", x_if.data, r_hold_data);
      end
      if (x_if.vld && x_if.rdy) begin
        if (q_exp.size() == 0) chk("sb_unexpected_pop", 32'd1, 32'd0);
        else chk("sb_data", x_if.data, q_exp.pop_front());
      end
      if (wr_vld && wr_rdy) q_exp.push_back(wr_data);
      r_hold      = x_if.vld && !x_if.rdy;
      r_hold_data = x_if.data;
    end
  end

  initial begin
    rst_n    = 1'b0;
    wr_vld   = 1'b0;
    wr_data  = '0;
    x_if.rdy = 1'b0;
    #1;
    chk("rst_fill", 32'(fill), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_vld", 32'(x_if.vld), 32'd0);
    chk("rst_wr_rdy", 32'(wr_rdy), 32'd1);
    chk("rst_xfer", 32'(xfer_cnt), 32'd0);
    tick(2);
    rst_n = 1'b1;

    // Single push with the sink ready.
    x_if.rdy = 1'b1;
    wr_vld   = 1'b1;
    wr_data  = 32'hA5A5A5A5;
    tick();
    wr_vld = 1'b0;
    chk("single_vld_c1", 32'(x_if.vld), 32'd1);
    chk("single_data_c1", x_if.data, 32'hA5A5A5A5);
    tick();
    chk("single_vld_c2", 32'(x_if.vld), 32'd0);
    chk("single_xfer", 32'(xfer_cnt), 32'd1);

    // Fill, overflow, hold, then drain.
    x_if.rdy = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      wr_vld  = 1'b1;
      wr_data = 32'(i);
      tick();
    end
    wr_vld = 1'b0;
    chk("full_fill", 32'(fill), 32'd4);
    chk("full_wr_rdy", 32'(wr_rdy), 32'd0);
    wr_vld  = 1'b1;
    wr_data = 32'h5;
    tick();
    wr_vld = 1'b0;
    chk("ovf_set", 32'(ovf), 32'd1);
    chk("ovf_fill", 32'(fill), 32'd4);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("hold_vld", 32'(x_if.vld), 32'd1);
      chk("hold_data", x_if.data, 32'h1);
    end
    x_if.rdy = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk("drain_data", x_if.data, 32'(i));
      chk("drain_vld", 32'(x_if.vld), 32'd1);
      tick();
    end
    chk("drain_empty", 32'(x_if.vld), 32'd0);
    chk("drain_xfer", 32'(xfer_cnt), 32'd5);
    chk("ovf_sticky", 32'(ovf), 32'd1);

    // Asynchronous reset with entries queued.
    x_if.rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wr_vld  = 1'b1;
      wr_data = 32'hB000_0000 + 32'(i);
      tick();
    end
    wr_vld = 1'b0;
    chk("pre_rst_fill", 32'(fill), 32'd3);
    rst_n = 1'b0;
    #1;
    chk("arst_fill", 32'(fill), 32'd0);
    chk("arst_ovf", 32'(ovf), 32'd0);
    chk("arst_vld", 32'(x_if.vld), 32'd0);
    chk("arst_wr_rdy", 32'(wr_rdy), 32'd1);
    tick(2);
    rst_n    = 1'b1;
    x_if.rdy = 1'b1;
    tick(3);
    chk("post_rst_vld", 32'(x_if.vld), 32'd0);
    chk("post_rst_xfer", 32'(xfer_cnt), 32'd0);

    // Streaming: one push per cycle with the sink always ready.
    for (int i = 0; i < 100; i++) begin
      wr_vld  = 1'b1;
      wr_data = 32'h1000 + 32'(i);
      tick();
      chk("stream_fill", 32'(fill), 32'd1);
    end
    wr_vld = 1'b0;
    chk("stream_xfer", 32'(xfer_cnt), 32'd99);
    tick();
    chk("stream_xfer_end", 32'(xfer_cnt), 32'd100);

    // Counter wrap: bring xfer_cnt to 0xFFFF, then two more transfers.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 65535; i++) begin
      wr_vld  = 1'b1;
      wr_data = 32'h5A5A_0000 ^ 32'(i);
      tick();
    end
    wr_vld = 1'b0;
    tick();
    chk("wrap_xfer_ffff", 32'(xfer_cnt), 32'hFFFF);
    chk("wrap_fill0", 32'(fill), 32'd0);
    for (int i = 0; i < 2; i++) begin
      wr_vld  = 1'b1;
      wr_data = 32'hC0DE_0000 + 32'(i);
      tick();
    end
    wr_vld = 1'b0;
    tick();
    chk("wrap_xfer_0001", 32'(xfer_cnt), 32'h0001);
    chk("wrap_fill_end", 32'(fill), 32'd0);
    chk("sb_drained", 32'(q_exp.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rdy_vld_src_tx.md
RDY_VLD_SRC_TX -- requirements
Module: rdy_vld_src_tx

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- DATA_W, 32: payload width of x.data and wr_data.
- DEPTH, 4: FIFO entries; power of two, 2..16.
REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, input, 1: single clock; all state on rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- wr_vld, input, 1: producer push request.
- wr_data, input, DATA_W: producer payload.
- wr_rdy, output, 1: FIFO can accept a push this cycle.
- x, rdy_vld_if.src, interface: transmit end of the ready/valid protocol.
- x.vld, output, 1: entry at the FIFO head is presented.
- x.data, output, DATA_W: FIFO head payload.
- x.rdy, input, 1: the downstream destination accepts.
- fill, output, $clog2(DEPTH)+1: current FIFO occupancy.
- ovf, output, 1: sticky flag set by a push attempted while full.
- xfer_cnt, output, 16: count of completed x transfers.
REQ-003 The block SHALL use exactly one clock, clk, and one reset, rst_n, which is asynchronous and active-low.

Function
REQ-004 The block SHALL be a DEPTH-entry FIFO with registered read and write pointers, each $clog2(DEPTH)+1 bits wide, including a wrap bit.
REQ-005 A push SHALL occur when wr_vld && wr_rdy, writing wr_data at the write pointer.
REQ-006 wr_rdy SHALL equal !full, where full means fill == DEPTH, and SHALL NOT depend combinationally on x.rdy.
REQ-007 A pop SHALL occur when x.vld && x.rdy.
REQ-008 x.vld SHALL equal (fill != 0), and x.data SHALL be the head entry.
REQ-009 Latency: a push into an empty FIFO SHALL raise x.vld on the next cycle; there is no combinational wr_data-to-x.data bypass.
REQ-010 Once x.vld is high, x.vld and x.data SHALL stay stable until the transfer completes.
REQ-011 A simultaneous push and pop SHALL leave fill unchanged and SHALL advance both pointers.
REQ-012 When full, a simultaneous push and pop SHALL NOT occur, because wr_rdy=0 blocks the push.
REQ-013 When full, the push SHALL be dropped and ovf SHALL be set to 1.
REQ-014 ovf SHALL stay set until reset.
REQ-015 Pointers SHALL wrap modulo 2*DEPTH.
REQ-016 empty SHALL be defined as pointers equal; full SHALL be defined as pointer indices equal with wrap bits differing.
REQ-017 fill SHALL equal wptr - rptr, modulo 2*DEPTH.
REQ-018 xfer_cnt SHALL increment by 1 on each pop and SHALL wrap from 0xFFFF to 0x0000.
REQ-019 wr_vld while wr_rdy=0 SHALL be legal and SHALL have no effect other than REQ-013.
REQ-020 x.rdy while x.vld=0 SHALL be ignored.

Reset
REQ-021 On rst_n=0, the block SHALL asynchronously clear pointers, fill, ovf and xfer_cnt, set x.vld=0, and set wr_rdy=1.
REQ-022 Storage array contents SHALL NOT be reset, and x.data SHALL be don't-care while x.vld=0.
REQ-023 Reset asserted mid-transfer SHALL discard all queued entries; the first post-reset x.vld SHALL occur only after a new push.
REQ-024 Deassertion of rst_n SHALL be synchronized externally; the block SHALL be functional on the first clk edge after deassertion.

Verification
REQ-025 Single push: with DEPTH=4 and x.rdy=1, push 0xA5A5A5A5 at cycle 0 -> x.vld=1 and x.data=0xA5A5A5A5 at cycle 1, x.vld=0 at cycle 2, and xfer_cnt=1.
REQ-026 Fill and backpressure: with x.rdy=0, push 0x1, 0x2, 0x3, 0x4 -> fill=4 and wr_rdy=0; a fifth push of 0x5 -> ovf=1 and fill=4; then set x.rdy=1 -> data out is 0x1, 0x2, 0x3, 0x4 on consecutive cycles, and 0x5 never appears.
REQ-027 Stability: hold x.rdy=0 for 10 cycles with x.vld=1 -> x.data does not change and x.vld stays 1; the assertion checking this runs throughout the test.
REQ-028 Streaming: continuous push with x.rdy=1 for 100 cycles -> fill stays at 1, data order is preserved, and xfer_cnt=99 at the end.
REQ-029 Wrap: preload xfer_cnt to 0xFFFF, run 2 transfers, and run enough traffic for 3 pointer wraps -> xfer_cnt=0x0001 and data order is intact.
REQ-030 Reset mid-operation: assert rst_n=0 with fill=3 and ovf=1 -> fill=0, ovf=0, x.vld=0, and wr_rdy=1 immediately without waiting for a clk edge.
